// File: rtl/pll_mdrp_pkg.sv
// Shared definitions for the PLLA MDRP initiator: MDRP opcodes, sequencer states and a
// counter-width helper.
package pll_mdrp_pkg;

  localparam logic [1:0] MDOP_NOP = 2'b00;
  localparam logic [1:0] MDOP_WR  = 2'b01;
  localparam logic [1:0] MDOP_RD  = 2'b10;
  localparam logic [1:0] MDOP_ALD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_DONE,
    S_PRST,
    S_PLOCK
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Brings the asynchronous PLL LOCK into the clk domain and only reports it stable after
// DEBOUNCE consecutive high samples.
module pll_lock_sync #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic pll_lock,
  output logic lock_stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], pll_lock};
      if (clr || !sync[1]) cnt <= '0;
      else if (cnt != CW'(DEBOUNCE)) cnt <= cnt + 1'b1;
    end
  end

  assign lock_stable = (cnt == CW'(DEBOUNCE));

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// MDRP initiator for PLLA: turns single register requests into MDCLK-framed bus cycles and
// sequences PLL reset / relock.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int unsigned MDCLK_HALF   = 4,
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  input  logic       apply,
  output logic       locked,
  output logic       timeout_err,
  output logic       pll_mdclk,
  output logic [1:0] pll_mdopc,
  output logic       pll_mdainc,
  output logic [7:0] pll_mdwdi,
  input  logic [7:0] pll_mdrdo,
  input  logic       pll_lock,
  output logic       pll_reset
);

  localparam int unsigned N  = 2 * MDCLK_HALF;
  localparam int unsigned CW = cnt_width(N, RST_CYCLES, LOCK_TIMEOUT);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    ptr, ptr_d, addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic          ptr_valid, ptr_valid_d, write_q, write_d;
  logic          locked_d, terr_d, lock_stable, lock_drop, period_end;
  logic          ready_d, rsp_valid_d, mdclk_d, ainc_d, rst_d;
  logic [1:0]    opc_d;
  logic [7:0]    wdi_d, rsp_rdata_d;

  pll_lock_sync #(.DEBOUNCE(16)) u_lock_sync (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (state == S_PRST),
    .pll_lock   (pll_lock),
    .lock_stable(lock_stable)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 1'b1;
    ptr_d       = ptr;
    ptr_valid_d = ptr_valid;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    locked_d    = locked;
    terr_d      = timeout_err;
    period_end  = (cnt == CW'(N - 1));
    lock_drop   = locked && !lock_stable;

    case (state)
      S_IDLE: begin
        cnt_d    = '0;
        locked_d = lock_stable;
        if (lock_drop) ptr_valid_d = 1'b0;
        if (apply) begin
          state_d     = S_PRST;
          terr_d      = 1'b0;
          ptr_valid_d = 1'b0;
          locked_d    = 1'b0;
        end else if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (ptr_valid && !lock_drop && req_addr == ptr) state_d = req_write ? S_WR : S_RD;
          else state_d = S_ADDR;
        end
      end
      S_ADDR: if (period_end) begin
        cnt_d       = '0;
        ptr_d       = addr_q;
        ptr_valid_d = 1'b1;
        state_d     = write_q ? S_WR : S_RD;
      end
      S_WR: if (period_end) begin
        cnt_d   = '0;
        ptr_d   = ptr + 8'd1;
        state_d = S_DONE;
      end
      S_RD: if (period_end) begin
        cnt_d   = '0;
        ptr_d   = ptr + 8'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Capture on the clk edge that raises MDCLK inside the wait period.
        if (cnt == CW'(MDCLK_HALF - 1)) rdata_d = pll_mdrdo;
        if (period_end) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_PRST: if (cnt == CW'(RST_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = S_PLOCK;
      end
      S_PLOCK: begin
        if (lock_stable) begin
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          terr_d   = 1'b1;
          locked_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so every PLL-facing pin is a flop.
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    rsp_rdata_d = (state_d == S_DONE) ? rdata_d : '0;
    rst_d       = (state_d == S_PRST);
    mdclk_d     = (state_d inside {S_ADDR, S_WR, S_RD, S_RD_WAIT}) && (cnt_d >= CW'(MDCLK_HALF));
    opc_d       = MDOP_NOP;
    ainc_d      = 1'b0;
    wdi_d       = '0;
    case (state_d)
      S_ADDR: begin
        opc_d = MDOP_ALD;
        wdi_d = addr_d;
      end
      S_WR: begin
        opc_d  = MDOP_WR;
        ainc_d = 1'b1;
        wdi_d  = wdata_d;
      end
      S_RD: begin
        opc_d  = MDOP_RD;
        ainc_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      ptr_valid   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      pll_mdclk   <= 1'b0;
      pll_mdopc   <= MDOP_NOP;
      pll_mdainc  <= 1'b0;
      pll_mdwdi   <= '0;
      pll_reset   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ptr         <= ptr_d;
      ptr_valid   <= ptr_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      locked      <= locked_d;
      timeout_err <= terr_d;
      req_ready   <= ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      pll_mdclk   <= mdclk_d;
      pll_mdopc   <= opc_d;
      pll_mdainc  <= ainc_d;
      pll_mdwdi   <= wdi_d;
      pll_reset   <= rst_d;
    end
  end

endmodule
